vga_fb_reader: RTL and testbench

VGA_FB_READER -- requirements
Module: vga_fb_reader

---
 rtl/vga_fb_reader.sv | 137 +++++++++++++
 tb/tb_vga_fb_reader.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/vga_fb_reader.sv
// VGA scan-out from a double-buffered 320x240 RGB444 frame memory, 2x upscaled to 640x480.
// Even output lines fetch from memory into a line buffer; odd lines replay it. Fixed 3-cycle latency.
module vga_fb_reader (
    input  logic        pixClock,
    input  logic        resetN,
    input  logic [10:0] hCount,
    input  logic [9:0]  vCount,
    input  logic        hSyncIn,
    input  logic        vSyncIn,
    input  logic        swapReq,
    output logic        swapAck,
    output logic [17:0] memAddr,
    output logic        memRdEn,
    input  logic [11:0] memData,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        hSync,
    output logic        vSync,
    output logic        pixActive
);

    localparam logic [17:0] BUF1_BASE = 18'd76800;

    logic [10:0] hx;
    logic [9:0]  vy;
    logic [8:0]  src_x;
    logic [7:0]  src_y;
    logic        in_win, fetch_line, rd_go, frame_start;
    logic [17:0] addr_nxt;

    logic        bufSel, lb_valid;
    logic        act1, fetch1, hs1, vs1;
    logic [8:0]  srcx1;
    logic        act2, fetch2, hs2, vs2, rd2;
    logic [8:0]  srcx2;
    logic [11:0] lb_q, pix;
    logic [11:0] lbuf [0:319];

    always_comb begin
        hx          = hCount - 11'd144;
        vy          = vCount - 10'd35;
        src_x       = 9'(hx >> 1);
        src_y       = 8'(vy >> 1);
        in_win      = (hCount >= 11'd144) && (hCount <= 11'd783) &&
                      (vCount >= 10'd35)  && (vCount <= 10'd514);
        fetch_line  = ~vy[0];
        rd_go       = in_win && fetch_line && ~hx[0];
        frame_start = (hCount == 11'd0) && (vCount == 10'd0);
        // srcY*320 as two shifts
        addr_nxt    = (bufSel ? BUF1_BASE : 18'd0)
                    + {2'b00, src_y, 8'b0}
                    + {4'b0000, src_y, 6'b0}
                    + {9'b0, src_x};
    end

    // Stage 1: address/strobe, buffer select, replay gating
    always_ff @(posedge pixClock or negedge resetN) begin
        if (!resetN) begin
            memRdEn  <= 1'b0;
            memAddr  <= 18'd0;
            bufSel   <= 1'b0;
            swapAck  <= 1'b0;
            lb_valid <= 1'b0;
            act1     <= 1'b0;
            fetch1   <= 1'b0;
            hs1      <= 1'b0;
            vs1      <= 1'b0;
            srcx1    <= 9'd0;
        end else begin
            memRdEn <= rd_go;
            if (rd_go)
                memAddr <= addr_nxt;
            swapAck <= frame_start && swapReq;
            if (frame_start && swapReq)
                bufSel <= ~bufSel;
            // line buffer only trusted once a fetch line was read from its first pixel
            if (rd_go && hx == 11'd0)
                lb_valid <= 1'b1;
            act1   <= in_win && (fetch_line || lb_valid);
            fetch1 <= fetch_line;
            hs1    <= hSyncIn;
            vs1    <= vSyncIn;
            srcx1  <= src_x;
        end
    end

    // Stage 2: memory word arrives / line buffer read
    always_ff @(posedge pixClock or negedge resetN) begin
        if (!resetN) begin
            act2   <= 1'b0;
            fetch2 <= 1'b0;
            hs2    <= 1'b0;
            vs2    <= 1'b0;
            rd2    <= 1'b0;
            srcx2  <= 9'd0;
        end else begin
            act2   <= act1;
            fetch2 <= fetch1;
            hs2    <= hs1;
            vs2    <= vs1;
            rd2    <= memRdEn;
            srcx2  <= srcx1;
        end
    end

    always_ff @(posedge pixClock) begin
        if (rd2)
            lbuf[srcx2] <= memData;
        lb_q <= lbuf[srcx1];
    end

    // Stage 3: colour out; odd fetch pixels hold the word fetched on the even one
    always_ff @(posedge pixClock or negedge resetN) begin
        if (!resetN) begin
            pix       <= 12'd0;
            pixActive <= 1'b0;
            hSync     <= 1'b0;
            vSync     <= 1'b0;
        end else begin
            if (!act2)
                pix <= 12'd0;
            else if (!fetch2)
                pix <= lb_q;
            else if (rd2)
                pix <= memData;
            pixActive <= act2;
            hSync     <= hs2;
            vSync     <= vs2;
        end
    end

    assign red   = pix[11:8];
    assign green = pix[7:4];
    assign blue  = pix[3:0];

endmodule

// File: tb/tb_vga_fb_reader.sv
// Scoreboard bench for vga_fb_reader: driver pushes expected memory-port (N+1) and pixel (N+3)
// responses; a negedge monitor pops and compares them.
module tb_vga_fb_reader;

    logic        pixClock = 1'b0;
    logic        resetN;
    logic [10:0] hCount;
    logic [9:0]  vCount;
    logic        hSyncIn, vSyncIn, swapReq;
    logic        swapAck, memRdEn, hSync, vSync, pixActive;
    logic [17:0] memAddr;
    logic [11:0] memData;
    logic [3:0]  red, green, blue;

    vga_fb_reader dut (
        .pixClock (pixClock), .resetN (resetN),
        .hCount (hCount), .vCount (vCount),
        .hSyncIn (hSyncIn), .vSyncIn (vSyncIn),
        .swapReq (swapReq), .swapAck (swapAck),
        .memAddr (memAddr), .memRdEn (memRdEn), .memData (memData),
        .red (red), .green (green), .blue (blue),
        .hSync (hSync), .vSync (vSync), .pixActive (pixActive)
    );

    always #5 pixClock = ~pixClock;

    // frame memory returns the low 12 address bits one cycle after the strobe
    always @(posedge pixClock) if (memRdEn) memData <= memAddr[11:0];

    typedef struct { int due; logic rd; logic [17:0] addr; logic ack; } e1_t;
    typedef struct { int due; logic act; logic [11:0] rgb; logic hs; logic vs; } e3_t;

    e1_t q1[$];
    e3_t q3[$];
    int  cyc = 0;
    int  checks = 0, errors = 0;

    logic        mbuf = 1'b0, mlbv = 1'b0;
    logic [17:0] mlast = 18'd0;
    logic [11:0] mlb [0:319];

    initial forever begin
        @(posedge pixClock);
        cyc++;
    end

    task automatic step(input int h, input int v, input logic hs, input logic vs,
                        input logic swp, input logic rst);
        e1_t e1;
        e3_t e3;
        int  hx, vy, sx, sy, addr;
        logic win, fetch, rd;
        @(posedge pixClock);
        #1;
        if (!rst && resetN) begin
            q1.delete();
            q3.delete();
            mbuf  = 1'b0;
            mlbv  = 1'b0;
            mlast = 18'd0;
        end
        resetN  = rst;
        swapReq = swp;
        hCount  = 11'(h);
        vCount  = 10'(v);
        hSyncIn = hs;
        vSyncIn = vs;
        e1.due = cyc + 1;
        e3.due = cyc + 3;
        if (!rst) begin
            e1.rd = 1'b0; e1.addr = 18'd0; e1.ack = 1'b0;
            e3.act = 1'b0; e3.rgb = 12'd0; e3.hs = 1'b0; e3.vs = 1'b0;
        end else begin
            hx    = h - 144;
            vy    = v - 35;
            win   = (h >= 144) && (h <= 783) && (v >= 35) && (v <= 514);
            sx    = win ? hx / 2 : 0;
            sy    = win ? vy / 2 : 0;
            fetch = (vy % 2) == 0;
            addr  = (mbuf ? 76800 : 0) + sy * 320 + sx;
            rd    = win && fetch && (hx % 2 == 0);
            e3.act = win && (fetch || mlbv);
            if (rd) begin
                mlast   = 18'(addr);
                mlb[sx] = 12'(addr);
                if (hx == 0) mlbv = 1'b1;
            end
            e3.rgb = !e3.act ? 12'd0 : (fetch ? 12'(addr) : mlb[sx]);
            e3.hs  = hs;
            e3.vs  = vs;
            e1.rd   = rd;
            e1.addr = mlast;
            e1.ack  = (h == 0) && (v == 0) && swp;
            if (e1.ack) mbuf = ~mbuf;
        end
        q1.push_back(e1);
        q3.push_back(e3);
    endtask

    task automatic line(input int v, input logic swp);
        for (int h = 0; h < 800; h++)
            step(h, v, h >= 96, v >= 2, swp, 1'b1);
    endtask

    initial begin : monitor
        e1_t e1;
        e3_t e3;
        forever begin
            @(negedge pixClock);
            if (!resetN) begin
                checks++;
                if ({red, green, blue, hSync, vSync, pixActive, memRdEn, memAddr, swapAck} != '0) begin
                    errors++;
                    $display("FAIL reset_outputs cyc=%0d got rgb=%h hs=%b vs=%b act=%b rd=%b addr=%0d ack=%b want all zero",
                             cyc, {red, green, blue}, hSync, vSync, pixActive, memRdEn, memAddr, swapAck);
                end
                while (q1.size() > 0 && q1[0].due <= cyc) void'(q1.pop_front());
                while (q3.size() > 0 && q3[0].due <= cyc) void'(q3.pop_front());
            end else begin
                if (q1.size() > 0 && q1[0].due == cyc) begin
                    e1 = q1.pop_front();
                    checks++;
                    if (memRdEn !== e1.rd || memAddr !== e1.addr || swapAck !== e1.ack) begin
                        errors++;
                        $display("FAIL mem_port cyc=%0d got rd=%b addr=%0d ack=%b want rd=%b addr=%0d ack=%b",
                                 cyc, memRdEn, memAddr, swapAck, e1.rd, e1.addr, e1.ack);
                    end
                end
                if (q3.size() > 0 && q3[0].due == cyc) begin
                    e3 = q3.pop_front();
                    checks++;
                    if (pixActive !== e3.act || {red, green, blue} !== e3.rgb ||
                        hSync !== e3.hs || vSync !== e3.vs) begin
                        errors++;
                        $display("FAIL pixel cyc=%0d got act=%b rgb=%h hs=%b vs=%b want act=%b rgb=%h hs=%b vs=%b",
                                 cyc, pixActive, {red, green, blue}, hSync, vSync, e3.act, e3.rgb, e3.hs, e3.vs);
                    end
                end
            end
        end
    end

    initial begin
        resetN = 1'b1; swapReq = 1'b0;
        hCount = '0; vCount = '0; hSyncIn = 1'b1; vSyncIn = 1'b1;
        #2 resetN = 1'b0;
        for (int i = 0; i < 4; i++) step(0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        // fetch line, its replay, and the last line pair of the image
        line(35, 1'b0);
        line(36, 1'b0);
        line(513, 1'b0);
        line(514, 1'b0);
        // mid-frame request is ignored, then taken at frame start
        for (int i = 0; i < 5; i++) step(400, 100, 1'b1, 1'b1, 1'b1, 1'b1);
        step(0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        line(35, 1'b1);
        // request still held: second frame start swaps back
        step(0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        // reset in the middle of a replay line
        for (int h = 0; h < 300; h++)   step(h, 100, h >= 96, 1'b1, 1'b0, 1'b1);
        for (int h = 300; h < 303; h++) step(h, 100, h >= 96, 1'b1, 1'b0, 1'b0);
        for (int h = 303; h < 800; h++) step(h, 100, h >= 96, 1'b1, 1'b0, 1'b1);
        line(101, 1'b0);
        line(102, 1'b0);
        for (int i = 0; i < 6; i++) step(0, 1, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge pixClock);
        @(negedge pixClock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
